// File: rtl/acc_hash_writeback.sv
// Hash write-back stage: captures the final SHA-256 digest, compares it against a difficulty target, and streams it to memory as 32-bit words.
// Optional HASH_WB_STATUS_EN adds a ninth status word: {29'b0, overrun_sticky, hash_meets_target, 1'b1}.
module acc_hash_writeback #(
  parameter logic [15:0] RESULT_START_ADDR = 16'h6000,
  parameter logic [15:0] ADDR_STRIDE       = 16'h0004
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         hash_done,
  input  logic [255:0] hash,
  input  logic         target_load,
  input  logic [255:0] target_in,
  input  logic         mem_acc_write_done,
  output logic         mem_acc_write_en,
  output logic [15:0]  mem_acc_write_addr,
  output logic [31:0]  mem_acc_write_data,
  output logic         busy,
  output logic         wb_done,
  output logic         hash_meets_target,
  output logic         overrun
);

  typedef enum logic [1:0] {IDLE, WRITE, STATUS, DONE} state_t;

  state_t         state_q, state_d;
  logic [2:0]     word_q;
  logic [255:0]   hash_q;
  logic [255:0]   target_q;
  logic           meets_q;
  logic           overrun_q;
  logic           capture;
  logic           drop;
  logic [2:0]     rev;
  logic [3:0]     idx;
`ifdef HASH_WB_STATUS_EN
  logic           sticky_q;
`endif

  assign capture = hash_done && (state_q == IDLE);
  assign drop    = hash_done && (state_q != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      word_q    <= '0;
      hash_q    <= '0;
      target_q  <= '1;
      meets_q   <= 1'b0;
      overrun_q <= 1'b0;
`ifdef HASH_WB_STATUS_EN
      sticky_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      overrun_q <= drop;
      // Compare uses the pre-load target when target_load coincides with capture.
      if (target_load)
        target_q <= target_in;
      if (capture) begin
        hash_q  <= hash;
        meets_q <= (hash <= target_q);
        word_q  <= '0;
      end else if (state_q == WRITE && mem_acc_write_done) begin
        word_q <= word_q + 3'd1;
      end
`ifdef HASH_WB_STATUS_EN
      // A drop in the same cycle as the status write's acceptance is kept for the next report.
      if (drop)
        sticky_q <= 1'b1;
      else if (state_q == STATUS && mem_acc_write_done)
        sticky_q <= 1'b0;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (hash_done) state_d = WRITE;
      WRITE:  if (mem_acc_write_done && word_q == 3'd7) begin
`ifdef HASH_WB_STATUS_EN
                state_d = STATUS;
`else
                state_d = DONE;
`endif
              end
      STATUS: if (mem_acc_write_done) state_d = DONE;
      DONE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_acc_write_en   = (state_q == WRITE) || (state_q == STATUS);
    rev                = 3'd7 - word_q;
    idx                = (state_q == STATUS) ? 4'd8 : {1'b0, word_q};
    mem_acc_write_addr = '0;
    mem_acc_write_data = '0;
    if (state_q == WRITE) begin
      mem_acc_write_addr = RESULT_START_ADDR + 16'(idx) * ADDR_STRIDE;
      mem_acc_write_data = hash_q[{rev, 5'd0} +: 32];
    end
`ifdef HASH_WB_STATUS_EN
    else if (state_q == STATUS) begin
      mem_acc_write_addr = RESULT_START_ADDR + 16'(idx) * ADDR_STRIDE;
      mem_acc_write_data = {29'b0, sticky_q, meets_q, 1'b1};
    end
`endif
  end

  assign busy              = (state_q != IDLE);
  assign wb_done           = (state_q == DONE);
  assign hash_meets_target = meets_q;
  assign overrun           = overrun_q;

endmodule

// File: tb/tb_acc_hash_writeback.sv
// Randomized self-checking bench for acc_hash_writeback against a word-list reference model.
module tb_acc_hash_writeback;

`ifdef HASH_WB_STATUS_EN
  localparam int NW = 9;
  localparam bit STATUS_ON = 1'b1;
`else
  localparam int NW = 8;
  localparam bit STATUS_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         hash_done;
  logic [255:0] hash;
  logic         target_load;
  logic [255:0] target_in;
  logic         mem_acc_write_done;
  logic         mem_acc_write_en;
  logic [15:0]  mem_acc_write_addr;
  logic [31:0]  mem_acc_write_data;
  logic         busy;
  logic         wb_done;
  logic         hash_meets_target;
  logic         overrun;

  int checks = 0;
  int errors = 0;

  logic [255:0] tgt_m;
  logic         meets_m;
  logic         sticky_m;

  acc_hash_writeback #(.RESULT_START_ADDR(16'h6000), .ADDR_STRIDE(16'h0004)) dut (
    .clk(clk), .rst_n(rst_n), .hash_done(hash_done), .hash(hash),
    .target_load(target_load), .target_in(target_in),
    .mem_acc_write_done(mem_acc_write_done), .mem_acc_write_en(mem_acc_write_en),
    .mem_acc_write_addr(mem_acc_write_addr), .mem_acc_write_data(mem_acc_write_data),
    .busy(busy), .wb_done(wb_done), .hash_meets_target(hash_meets_target), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] r = '0;
    for (int i = 0; i < 8; i++) r = {r[223:0], 32'($urandom())};
    return r;
  endfunction

  function automatic logic [31:0] exp_word(input logic [255:0] h, input int j);
    logic [255:0] sh;
    if (j < 8) begin
      sh = h >> (32 * (7 - j));
      return sh[31:0];
    end
    return {29'b0, sticky_m, meets_m, 1'b1};
  endfunction

  // One capture plus write-back; ovr_word injects a dropped hash_done at that word (NW = DONE cycle),
  // rst_word pulses reset at that word instead of completing.
  task automatic run_transfer(input logic [255:0] h, input int dly, input int ovr_word,
                              input int rst_word, input bit ld, input logic [255:0] new_tgt);
    int  k = 0;
    int  wt = 0;
    bit  prev_inj = 0;
    bit  finished = 0;
    @(negedge clk);
    hash = h;
    hash_done = 1'b1;
    if (ld) begin
      target_load = 1'b1;
      target_in = new_tgt;
    end
    meets_m = (h <= tgt_m);
    if (ld) tgt_m = new_tgt;
    for (int cyc = 1; cyc <= 300; cyc++) begin
      @(negedge clk);
      hash_done = 1'b0;
      target_load = 1'b0;
      mem_acc_write_done = 1'b0;
      if (cyc == 1) check("meets_after_capture", hash_meets_target, meets_m);
      check("overrun", overrun, prev_inj);
      prev_inj = 0;
      check("wb_done", wb_done, k == NW);
      check("busy", busy, 1'b1);
      if (k == NW) begin
        check("en_in_done", mem_acc_write_en, 1'b0);
        if (dly == 0) check("latency", cyc, NW + 1);
        if (ovr_word == NW) begin
          hash_done = 1'b1;
          hash = ~h;
          prev_inj = 1;
          sticky_m = STATUS_ON;
        end
        finished = 1;
        break;
      end
      check("en", mem_acc_write_en, 1'b1);
      check("addr", mem_acc_write_addr, 16'h6000 + 16'(k * 4));
      check("data", mem_acc_write_data, exp_word(h, k));
      if (k == rst_word) begin
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("rst_en", mem_acc_write_en, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_wb_done", wb_done, 1'b0);
        check("rst_meets", hash_meets_target, 1'b0);
        tgt_m = '1;
        meets_m = 1'b0;
        sticky_m = 1'b0;
        return;
      end
      if (k == ovr_word && !prev_inj) begin
        hash_done = 1'b1;
        hash = ~h;
        prev_inj = 1;
        sticky_m = STATUS_ON;
      end
      if (wt == dly) begin
        mem_acc_write_done = 1'b1;
        if (k == 8) sticky_m = 1'b0;
        k++;
        wt = 0;
      end else begin
        wt++;
      end
    end
    if (!finished) check("wb_done_timeout", 1'b0, 1'b1);
    @(negedge clk);
    hash_done = 1'b0;
    check("post_overrun", overrun, prev_inj);
    check("post_busy", busy, 1'b0);
    check("post_wb_done", wb_done, 1'b0);
    check("post_en", mem_acc_write_en, 1'b0);
    check("meets_held", hash_meets_target, meets_m);
  endtask

  task automatic load_target(input logic [255:0] t);
    @(negedge clk);
    target_load = 1'b1;
    target_in = t;
    tgt_m = t;
    @(negedge clk);
    target_load = 1'b0;
  endtask

  initial begin
    logic [255:0] h;
    logic [255:0] t;
    rst_n = 1'b0;
    hash_done = 1'b0;
    hash = '0;
    target_load = 1'b0;
    target_in = '0;
    mem_acc_write_done = 1'b0;
    tgt_m = '1;
    meets_m = 1'b0;
    sticky_m = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_en", mem_acc_write_en, 1'b0);
    check("reset_addr", mem_acc_write_addr, 16'h0000);
    check("reset_data", mem_acc_write_data, 32'h0);
    check("reset_busy", busy, 1'b0);
    check("reset_wb_done", wb_done, 1'b0);
    check("reset_meets", hash_meets_target, 1'b0);
    check("reset_overrun", overrun, 1'b0);
    rst_n = 1'b1;

    run_transfer({4{64'h0123456789ABCDEF}}, 0, -1, -1, 0, '0);
    check("seq_meets_default", hash_meets_target, 1'b1);

    load_target({32'h0000FFFF, 224'h0});
    run_transfer({32'h0000FFFF, 224'h0}, 0, -1, -1, 0, '0);
    check("meets_equal", hash_meets_target, 1'b1);
    run_transfer({32'h00010000, 224'h0}, 0, -1, -1, 0, '0);
    check("meets_above", hash_meets_target, 1'b0);

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      mem_acc_write_done = 1'b1;
      @(negedge clk);
      mem_acc_write_done = 1'b0;
      check("idle_en", mem_acc_write_en, 1'b0);
      check("idle_busy", busy, 1'b0);
    end
    run_transfer(rand256(), 3, -1, -1, 0, '0);

    run_transfer(rand256() >> 20, 0, 3, -1, 0, '0);
    run_transfer(rand256() >> 20, 1, -1, -1, 0, '0);

    run_transfer(rand256(), 0, -1, 5, 0, '0);
    run_transfer(rand256(), 0, -1, -1, 0, '0);

    h = rand256();
    run_transfer(h, 0, -1, -1, 1, '0);
    run_transfer(h, 0, -1, -1, 0, '0);

    for (int i = 0; i < 12; i++) begin
      h = rand256();
      case ($urandom_range(0, 2))
        0: t = h;
        1: t = h - 256'd1;
        default: t = rand256();
      endcase
      load_target(t);
      run_transfer(h, $urandom_range(0, 2), ($urandom_range(0, 3) == 0) ? NW : -1, -1, 0, '0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
